// File: rtl/counter_mod.sv
// Multi-channel up/down modulo counter with clear, clamped parallel load,
// wrap/saturate limit handling, terminal-count pulses and sticky overflow.
module counter_mod #(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_COUNT = 2**WIDTH - 1,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [CHANNELS-1:0]              clear,
  input  logic [CHANNELS-1:0]              load,
  input  logic [CHANNELS-1:0][WIDTH-1:0]   load_val,
  input  logic [CHANNELS-1:0]              incr,
  input  logic [CHANNELS-1:0]              decr,
  output logic [CHANNELS-1:0][WIDTH-1:0]   count_reg,
  output logic [CHANNELS-1:0]              tc,
  output logic [CHANNELS-1:0]              ovf
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_COUNT);

  logic [CHANNELS-1:0][WIDTH-1:0] count_nxt;
  logic [CHANNELS-1:0]            tc_nxt;
  logic [CHANNELS-1:0]            ovf_nxt;

  // Per-channel priority: clear > load > incr&decr > incr > decr > hold.
  always_comb begin
    count_nxt = count_reg;
    tc_nxt    = '0;
    ovf_nxt   = ovf;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (clear[i]) begin
        count_nxt[i] = '0;
        ovf_nxt[i]   = 1'b0;
      end else if (load[i]) begin
        count_nxt[i] = (load_val[i] > MAX) ? MAX : load_val[i];
      end else if (incr[i] && decr[i]) begin
        count_nxt[i] = count_reg[i];
      end else if (incr[i]) begin
        if (count_reg[i] == MAX) begin
          tc_nxt[i]  = 1'b1;
          ovf_nxt[i] = 1'b1;
          if (!SATURATE) count_nxt[i] = '0;
        end else begin
          count_nxt[i] = count_reg[i] + WIDTH'(1);
        end
      end else if (decr[i]) begin
        if (count_reg[i] == '0) begin
          tc_nxt[i]  = 1'b1;
          ovf_nxt[i] = 1'b1;
          if (!SATURATE) count_nxt[i] = MAX;
        end else begin
          count_nxt[i] = count_reg[i] - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
      tc        <= '0;
      ovf       <= '0;
    end else begin
      count_reg <= count_nxt;
      tc        <= tc_nxt;
      ovf       <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_counter_mod.sv
// Directed bench for counter_mod: wrap instance driven from a vector table,
// saturate instance exercised by hand-written multi-cycle sequences.
module tb_counter_mod;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [1:0]          clear, load, incr, decr;
  logic [1:0][7:0]     load_val;
  logic [1:0][7:0]     count_reg, count_s;
  logic [1:0]          tc, ovf, tc_s, ovf_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_mod #(.CHANNELS(2), .WIDTH(8), .MAX_COUNT(9), .SATURATE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_val(load_val),
    .incr(incr), .decr(decr), .count_reg(count_reg), .tc(tc), .ovf(ovf)
  );

  counter_mod #(.CHANNELS(2), .WIDTH(8), .MAX_COUNT(9), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_val(load_val),
    .incr(incr), .decr(decr), .count_reg(count_s), .tc(tc_s), .ovf(ovf_s)
  );

  typedef struct {
    logic       rst_n;
    logic [1:0] clr, ld, inc, dec;
    logic [7:0] lv0, lv1;
    logic [7:0] c0, c1;
    logic [1:0] tc, ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [1:0] clr, input logic [1:0] ld,
                              input logic [7:0] lv0, input logic [7:0] lv1,
                              input logic [1:0] inc, input logic [1:0] dec,
                              input logic [7:0] c0, input logic [7:0] c1,
                              input logic [1:0] t, input logic [1:0] o);
    vec_t v;
    v.rst_n = r; v.clr = clr; v.ld = ld; v.lv0 = lv0; v.lv1 = lv1;
    v.inc = inc; v.dec = dec; v.c0 = c0; v.c1 = c1; v.tc = t; v.ovf = o;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] clr, input logic [1:0] ld,
                       input logic [7:0] lv0, input logic [7:0] lv1,
                       input logic [1:0] inc, input logic [1:0] dec);
    @(negedge clk);
    rst_n = r; clear = clr; load = ld; load_val[0] = lv0; load_val[1] = lv1;
    incr = inc; decr = dec;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clear = '0; load = '0; load_val = '0; incr = '0; decr = '0;

    // reset with incr active, then release and count ch0
    vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 2'b00, 2'b00));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 1, 0, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 2, 0, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 3, 0, 2'b00, 2'b00));
    // wrap up then underflow down
    vecs.push_back(mk(1, 2'b01, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00));
    for (int k = 1; k <= 9; k++)
      vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 8'(k), 0, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 0, 0, 2'b01, 2'b01));
    vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 2'b00, 2'b01, 9, 0, 2'b01, 2'b01));
    vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 9, 0, 2'b00, 2'b01));
    // priority: load>incr, incr&decr, clear>load
    vecs.push_back(mk(1, 2'b00, 2'b01, 5, 0, 2'b01, 2'b00, 5, 0, 2'b00, 2'b01));
    vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 2'b01, 2'b01, 5, 0, 2'b00, 2'b01));
    vecs.push_back(mk(1, 2'b01, 2'b01, 7, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00));
    // load clamp, ovf survives load, clear drops it
    vecs.push_back(mk(1, 2'b00, 2'b01, 200, 0, 2'b00, 2'b00, 9, 0, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 0, 0, 2'b01, 2'b01));
    vecs.push_back(mk(1, 2'b00, 2'b01, 3, 0, 2'b00, 2'b00, 3, 0, 2'b00, 2'b01));
    vecs.push_back(mk(1, 2'b01, 2'b00, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00));
    // ch0 to 7, ch1 underflows (ovf) then loads 4; reset mid-count
    vecs.push_back(mk(1, 2'b00, 2'b01, 7, 0, 2'b00, 2'b10, 7, 9, 2'b10, 2'b10));
    vecs.push_back(mk(1, 2'b00, 2'b10, 0, 4, 2'b00, 2'b00, 7, 4, 2'b00, 2'b10));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 0, 0, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 1, 1, 2'b00, 2'b00));
    vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 2, 2, 2'b00, 2'b00));
    // load at exactly MAX and just above it
    vecs.push_back(mk(1, 2'b00, 2'b11, 9, 10, 2'b00, 2'b00, 9, 9, 2'b00, 2'b00));

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].clr, vecs[i].ld, vecs[i].lv0, vecs[i].lv1,
            vecs[i].inc, vecs[i].dec);
      check($sformatf("v%0d count0", i), 32'(count_reg[0]), 32'(vecs[i].c0));
      check($sformatf("v%0d count1", i), 32'(count_reg[1]), 32'(vecs[i].c1));
      check($sformatf("v%0d tc", i),     32'(tc),           32'(vecs[i].tc));
      check($sformatf("v%0d ovf", i),    32'(ovf),          32'(vecs[i].ovf));
    end

    // saturate: 12 incr from 0 sticks at 9, tc high on the last 3
    drive(1, 2'b11, 2'b00, 0, 0, 2'b00, 2'b00);
    check("sat clear count0", 32'(count_s[0]), 0);
    check("sat clear ovf", 32'(ovf_s), 0);
    for (int k = 1; k <= 12; k++) begin
      drive(1, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00);
      check($sformatf("sat inc%0d count0", k), 32'(count_s[0]), (k > 9) ? 9 : k);
      check($sformatf("sat inc%0d tc0", k),    32'(tc_s[0]),    (k > 9) ? 1 : 0);
      check($sformatf("sat inc%0d ovf0", k),   32'(ovf_s[0]),   (k > 9) ? 1 : 0);
      check($sformatf("sat inc%0d count1", k), 32'(count_s[1]), 0);
    end
    // saturate underflow on ch1 holds at 0, repeated tc
    for (int k = 1; k <= 2; k++) begin
      drive(1, 2'b00, 2'b00, 0, 0, 2'b00, 2'b10);
      check($sformatf("sat dec%0d count1", k), 32'(count_s[1]), 0);
      check($sformatf("sat dec%0d tc1", k),    32'(tc_s[1]),    1);
      check($sformatf("sat dec%0d ovf1", k),   32'(ovf_s[1]),   1);
    end
    drive(1, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00);
    check("sat hold tc", 32'(tc_s), 0);
    check("sat hold ovf", 32'(ovf_s), 3);

    // reset is synchronous: no output change before the edge
    @(negedge clk);
    rst_n = 1'b0; incr = 2'b00; decr = 2'b00;
    #1;
    check("sync rst pre-edge count0", 32'(count_s[0]), 9);
    check("sync rst pre-edge ovf", 32'(ovf_s), 3);
    @(posedge clk);
    #1;
    check("sync rst post-edge count0", 32'(count_s[0]), 0);
    check("sync rst post-edge ovf", 32'(ovf_s), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
